// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared types and constants for the OV7670 configuration sequencer
package ov7670_pkg;

    localparam int ROM_ADDR_W = 7;
    localparam int ROM_DATA_W = 16;
    localparam int WAIT_W     = 24;

    localparam logic [ROM_DATA_W-1:0] CAM_END_MARKER = 16'hFFFF;
    localparam logic [7:0]            CAM_DELAY_REG  = 8'hF0;
    localparam logic [ROM_ADDR_W-1:0] ROM_LAST_ADDR  = '1;

    typedef enum logic [3:0] {
        IDLE,
        PWR_RST,
        BOOT_WAIT,
        FETCH,
        DECODE,
        ISSUE,
        WAIT_DONE,
        SETTLE,
        DELAY,
        DONE,
        ERROR
    } cfg_state_t;

endpackage

// File: rtl/cfg_wait_timer.sv
// rtl/cfg_wait_timer.sv - down-counting wait timer shared by all timed sequencer states
module cfg_wait_timer
    import ov7670_pkg::*;
(
    input  logic              clk,
    input  logic              reset_,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              tick,
    output logic              expired
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - WAIT_W'(1);
        end
    end

    // Flags the final cycle of a wait: a load of N occupies exactly N cycles, minimum one.
    assign expired = (count <= WAIT_W'(1));

endmodule

// File: rtl/ov7670_cfg_seq.sv
// rtl/ov7670_cfg_seq.sv - OV7670 power-up and register-table configuration sequencer
module ov7670_cfg_seq
    import ov7670_pkg::*;
#(
    parameter int CYCLES_PER_MS = 50000,
    parameter int T_RST_MS      = 2,
    parameter int T_BOOT_MS     = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  start,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [ROM_DATA_W-1:0] rom_data,
    output logic                  i2c_req,
    output logic [7:0]            i2c_reg,
    output logic [7:0]            i2c_val,
    input  logic                  i2c_ack,
    input  logic                  i2c_done,
    input  logic                  i2c_nack,
    output logic                  cam_pwdn,
    output logic                  cam_rst_,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ROM_ADDR_W-1:0] err_idx
);

    localparam logic [WAIT_W-1:0] RST_LOAD    = WAIT_W'(T_RST_MS * CYCLES_PER_MS);
    localparam logic [WAIT_W-1:0] BOOT_LOAD   = WAIT_W'(T_BOOT_MS * CYCLES_PER_MS);
    localparam logic [WAIT_W-1:0] SETTLE_LOAD = WAIT_W'(SETTLE_CYCLES);
    localparam logic [WAIT_W-1:0] MS_CYCLES   = WAIT_W'(CYCLES_PER_MS);
    localparam logic [7:0]        RETRY_LIMIT = 8'(MAX_RETRIES);

    cfg_state_t        state;
    logic [7:0]        retries;
    logic              tmr_load;
    logic [WAIT_W-1:0] tmr_val;
    logic              tmr_tick;
    logic              tmr_expired;

    logic start_ok;
    logic is_end;
    logic is_delay;
    logic wr_fin;
    logic wr_ok;

    assign start_ok = start && (state == IDLE || state == DONE || state == ERROR);
    assign is_end   = (rom_data == CAM_END_MARKER);
    assign is_delay = (rom_data[15:8] == CAM_DELAY_REG);
    // An ack and done arriving together in ISSUE completes the write in that same cycle.
    assign wr_fin   = i2c_done && ((state == WAIT_DONE) || (state == ISSUE && i2c_ack));
    assign wr_ok    = wr_fin && !i2c_nack;
    assign tmr_tick = (state == PWR_RST) || (state == BOOT_WAIT) ||
                      (state == SETTLE)  || (state == DELAY);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (start_ok) begin
            tmr_load = 1'b1;
            tmr_val  = RST_LOAD;
        end else if (state == PWR_RST && tmr_expired) begin
            tmr_load = 1'b1;
            tmr_val  = BOOT_LOAD;
        end else if (state == DECODE && !is_end && is_delay) begin
            tmr_load = 1'b1;
            tmr_val  = WAIT_W'(rom_data[7:0]) * MS_CYCLES;
        end else if (wr_ok) begin
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
        end
    end

    cfg_wait_timer u_wait_timer (
        .clk      (clk),
        .reset_   (reset_),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= IDLE;
            rom_addr <= '0;
            i2c_req  <= 1'b0;
            i2c_reg  <= '0;
            i2c_val  <= '0;
            cam_pwdn <= 1'b1;
            cam_rst_ <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_idx  <= '0;
            retries  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state    <= PWR_RST;
                        rom_addr <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cam_pwdn <= 1'b0;
                        cam_rst_ <= 1'b0;
                    end
                end
                PWR_RST: begin
                    if (tmr_expired) begin
                        cam_rst_ <= 1'b1;
                        state    <= BOOT_WAIT;
                    end
                end
                BOOT_WAIT: begin
                    if (tmr_expired) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    if (is_end) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (is_delay) begin
                        state <= DELAY;
                    end else begin
                        i2c_reg <= rom_data[15:8];
                        i2c_val <= rom_data[7:0];
                        retries <= '0;
                        i2c_req <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i2c_ack) begin
                        i2c_req <= 1'b0;
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                end
                SETTLE, DELAY: begin
                    if (tmr_expired) begin
                        if (rom_addr == ROM_LAST_ADDR) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Completion handling overrides the ISSUE branch above when ack and done coincide.
            if (wr_fin) begin
                if (!i2c_nack) begin
                    state <= SETTLE;
                end else if (retries < RETRY_LIMIT) begin
                    retries <= retries + 8'd1;
                    i2c_req <= 1'b1;
                    state   <= ISSUE;
                end else begin
                    error   <= 1'b1;
                    busy    <= 1'b0;
                    err_idx <= rom_addr;
                    state   <= ERROR;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// tb/tb_ov7670_cfg_seq.sv - table-driven self-checking bench for ov7670_cfg_seq
module tb_ov7670_cfg_seq;

    logic        clk = 1'b0;
    logic        reset_;
    logic        start;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic        i2c_req;
    logic [7:0]  i2c_reg, i2c_val;
    logic        i2c_ack, i2c_done, i2c_nack;
    logic        cam_pwdn, cam_rst_, busy, done, error;
    logic [6:0]  err_idx;

    ov7670_cfg_seq #(
        .CYCLES_PER_MS (10),
        .T_RST_MS      (1),
        .T_BOOT_MS     (2),
        .SETTLE_CYCLES (16),
        .MAX_RETRIES   (3)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .i2c_req  (i2c_req),
        .i2c_reg  (i2c_reg),
        .i2c_val  (i2c_val),
        .i2c_ack  (i2c_ack),
        .i2c_done (i2c_done),
        .i2c_nack (i2c_nack),
        .cam_pwdn (cam_pwdn),
        .cam_rst_ (cam_rst_),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_idx  (err_idx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [15:0] rom_tab [0:127];
    always @(posedge clk) rom_data <= rom_tab[rom_addr];

    // Master model state and write log
    int   mst_lat = 3;
    bit   mst_fast = 0;
    bit   mst_hold = 0;
    bit   mst_flush = 0;
    bit   mst_infl = 0;
    int   mst_cnt = 0;
    bit   mst_nk = 0;
    int   nack_idx = -1;
    int   nack_left = 0;
    int   wr_n = 0;
    logic [7:0] wr_reg [0:255];
    logic [7:0] wr_val [0:255];
    logic [6:0] wr_addr [0:255];
    int   wr_cyc [0:255];
    int   done_cyc [0:255];

    initial begin
        i2c_ack = 0; i2c_done = 0; i2c_nack = 0;
        forever begin
            @(negedge clk);
            i2c_ack = 0; i2c_done = 0; i2c_nack = 0;
            if (mst_flush) begin
                mst_infl = 0;
                mst_flush = 0;
            end else if (mst_infl) begin
                mst_cnt--;
                if (mst_cnt <= 0) begin
                    i2c_done = 1;
                    i2c_nack = mst_nk;
                    if (wr_n > 0) done_cyc[wr_n-1] = cyc;
                    mst_infl = 0;
                end
            end else if (i2c_req && !mst_hold) begin
                if (wr_n < 256) begin
                    wr_reg[wr_n] = i2c_reg;
                    wr_val[wr_n] = i2c_val;
                    wr_addr[wr_n] = rom_addr;
                    wr_cyc[wr_n] = cyc;
                end
                wr_n++;
                mst_nk = (nack_left > 0) && (int'(rom_addr) == nack_idx);
                if (mst_nk) nack_left--;
                i2c_ack = 1;
                if (mst_fast) begin
                    i2c_done = 1;
                    i2c_nack = mst_nk;
                    if (wr_n <= 256) done_cyc[wr_n-1] = cyc;
                end else begin
                    mst_infl = 1;
                    mst_cnt = mst_lat;
                end
            end
        end
    end

    int rst_low_n = 0;
    int rst_fall_n = 0;
    int rst_rise_cyc = 0;
    int req_hi_n = 0;
    logic prev_rst = 1'b0;
    always @(negedge clk) begin
        if (busy && !cam_rst_) rst_low_n++;
        if (busy && prev_rst && !cam_rst_) rst_fall_n++;
        if (!prev_rst && cam_rst_) rst_rise_cyc = cyc;
        if (i2c_req) req_hi_n++;
        prev_rst = cam_rst_;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic load_tab(input int t);
        for (int k = 0; k < 128; k++) rom_tab[k] = 16'hFFFF;
        case (t)
            0: begin
                rom_tab[0] = 16'h1280; rom_tab[1] = 16'hF003;
                rom_tab[2] = 16'h1101; rom_tab[3] = 16'hFFFF;
            end
            1: for (int k = 0; k < 128; k++) rom_tab[k] = {1'b0, 7'(k), ~8'(k)};
            2: begin
                rom_tab[0] = 16'h1280; rom_tab[1] = 16'h1101;
                rom_tab[2] = 16'h3A04; rom_tab[3] = 16'hFFFF;
            end
            default: begin
                rom_tab[0] = 16'hF000; rom_tab[1] = 16'h55AA; rom_tab[2] = 16'hFFFF;
            end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ = 0;
        mst_flush = 1;
        repeat (3) @(negedge clk);
        wr_n = 0;
        reset_ = 1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_end(input string nm, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (done || error) break;
            @(negedge clk);
        end
        if (!(done || error)) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout after %0d cycles, required done or error", nm, budget);
        end
    endtask

    typedef struct {
        int tab;
        int nack_idx;
        int nack_n;
        bit fast;
        int exp_wr;
        bit exp_done;
        bit exp_err;
        int exp_eidx;
        int exp_addr;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        bit ok;
        int k;

        vecs[0] = '{0, -1, 0,  1'b0, 2,   1'b1, 1'b0, 0, 3};
        vecs[1] = '{0, 2,  2,  1'b0, 4,   1'b1, 1'b0, 0, 3};
        vecs[2] = '{2, 1,  99, 1'b0, 5,   1'b0, 1'b1, 1, 1};
        vecs[3] = '{2, 1,  3,  1'b0, 6,   1'b1, 1'b0, 0, 3};
        vecs[4] = '{2, -1, 0,  1'b1, 3,   1'b1, 1'b0, 0, 3};
        vecs[5] = '{1, -1, 0,  1'b0, 128, 1'b1, 1'b0, 0, 127};
        vecs[6] = '{3, -1, 0,  1'b0, 1,   1'b1, 1'b0, 0, 2};
        vecs[7] = '{2, 1,  2,  1'b1, 5,   1'b1, 1'b0, 0, 3};

        reset_ = 0;
        start = 0;
        load_tab(0);
        repeat (3) @(negedge clk);
        reset_ = 1;
        @(negedge clk);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_i2c_req", i2c_req, 0);
        chk("rst_i2c_reg", i2c_reg, 0);
        chk("rst_i2c_val", i2c_val, 0);
        chk("rst_cam_pwdn", cam_pwdn, 1);
        chk("rst_cam_rst_", cam_rst_, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_error", {done, error}, 0);
        chk("rst_err_idx", err_idx, 0);

        for (int i = 0; i < NV; i++) begin
            load_tab(vecs[i].tab);
            nack_idx = vecs[i].nack_idx;
            nack_left = vecs[i].nack_n;
            mst_fast = vecs[i].fast;
            mst_hold = 0;
            mst_lat = 3;
            do_reset();
            rst_low_n = 0;
            pulse_start();
            wait_end($sformatf("v%0d_end", i), 20000);
            chk($sformatf("v%0d_writes", i), wr_n, vecs[i].exp_wr);
            chk($sformatf("v%0d_done", i), done, vecs[i].exp_done);
            chk($sformatf("v%0d_error", i), error, vecs[i].exp_err);
            chk($sformatf("v%0d_err_idx", i), err_idx, vecs[i].exp_eidx);
            chk($sformatf("v%0d_rom_addr", i), rom_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_rst_low", i), rst_low_n, 10);
            ok = 1;
            for (k = 0; k < wr_n && k < 256; k++)
                if ({wr_reg[k], wr_val[k]} !== rom_tab[wr_addr[k]]) ok = 0;
            chk($sformatf("v%0d_wr_content", i), ok, 1);
        end

        // Boot/gap timing, start ignored during BOOT_WAIT, then restart from DONE
        load_tab(0);
        nack_idx = -1; nack_left = 0; mst_fast = 0; mst_lat = 3;
        do_reset();
        rst_fall_n = 0;
        pulse_start();
        for (k = 0; k < 200 && !cam_rst_; k++) @(negedge clk);
        chk("boot_reached", cam_rst_, 1);
        repeat (3) @(negedge clk);
        pulse_start();
        wait_end("restart_first", 2000);
        chk("boot_no_restart", rst_fall_n, 0);
        chk("boot_writes", wr_n, 2);
        chk("boot_to_req", wr_cyc[0] - rst_rise_cyc, 22);
        chk("delay_gap", wr_cyc[1] - done_cyc[0], 16 + 30 + 5);
        chk("gap_second_write", {wr_reg[1], wr_val[1]}, 16'h1101);
        pulse_start();
        chk("restart_rom_addr", rom_addr, 0);
        chk("restart_busy_done", {busy, done, cam_rst_}, 3'b100);
        wait_end("restart_second", 2000);
        chk("restart_writes", wr_n, 4);
        chk("restart_done", done, 1);

        // Reset during WAIT_DONE
        mst_lat = 30;
        do_reset();
        pulse_start();
        for (k = 0; k < 500 && !(mst_infl && !i2c_req); k++) @(negedge clk);
        chk("wd_reached", {mst_infl, i2c_req}, 2'b10);
        @(posedge clk);
        #2 reset_ = 0;
        mst_flush = 1;
        #1;
        chk("wd_reset_pins", {i2c_req, cam_pwdn, cam_rst_, busy}, 4'b0100);

        // Reset during ISSUE drops the request the same cycle
        @(negedge clk);
        reset_ = 1;
        mst_hold = 1;
        pulse_start();
        for (k = 0; k < 500 && !i2c_req; k++) @(negedge clk);
        chk("issue_reached", i2c_req, 1);
        @(posedge clk);
        #2 reset_ = 0;
        #1;
        chk("issue_reset_req", i2c_req, 0);
        @(negedge clk);
        reset_ = 1;
        req_hi_n = 0;
        repeat (100) @(negedge clk);
        chk("post_reset_quiet", {req_hi_n[7:0], busy}, 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
